// File: rtl/top_mul.sv
// top_mul: two-stage pipelined unsigned multiplier with optional dropping of
// the TRUNC least-significant partial-product columns.
// Stage 1 registers the operands. The partial products of the registered
// operands are reduced by a carry-save array, and a final carry-propagate add
// feeds the stage-2 product register P.
module top_mul #(
  parameter int width1   = 8,
  parameter int width2   = 8,
  parameter int outwidth = 16,
  parameter int TRUNC    = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [width1-1:0]   IN1,
  input  logic [width2-1:0]   IN2,
  output logic [outwidth-1:0] P
);

  // Full product width; every partial-product column fits in it.
  localparam int FW = width1 + width2;

  logic [width1-1:0]   a_q;
  logic [width2-1:0]   b_q;
  logic [FW-1:0]       row;
  logic [FW-1:0]       s_n;
  logic [FW-1:0]       c_n;
  logic [FW-1:0]       sum_v;
  logic [FW-1:0]       carry_v;
  logic [FW-1:0]       prod_full;
  logic [outwidth-1:0] p_d;
  logic [outwidth-1:0] p_q;

  // Stage 1: capture the operands, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else begin
      a_q <= IN1;
      b_q <= IN2;
    end
  end

  // Carry-save reduction of the kept partial products, one row per IN2 bit.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    sum_v   = '0;
    carry_v = '0;
    row     = '0;
    s_n     = '0;
    c_n     = '0;
    for (int j = 0; j < width2; j++) begin
      row = '0;
      for (int i = 0; i < width1; i++) begin
        // Columns below TRUNC are dropped entirely; they never generate carries.
        if (i + j >= TRUNC) begin
          row[i+j] = a_q[i] & b_q[j];
        end
      end
      // 3:2 compression of (sum, carry, new row) keeps the carries unresolved.
      s_n     = sum_v ^ carry_v ^ row;
      c_n     = ((sum_v & carry_v) | (sum_v & row) | (carry_v & row)) << 1;
      sum_v   = s_n;
      carry_v = c_n;
    end
  end

  // Final carry-propagate add; the product always fits in FW bits.
  assign prod_full = sum_v + carry_v;

  // Fit the full product to the output width: keep low bits or zero-extend.
  generate
    if (outwidth <= FW) begin : g_narrow
      assign p_d = prod_full[outwidth-1:0];
    end else begin : g_wide
      assign p_d = {{(outwidth - FW){1'b0}}, prod_full};
    end
  endgenerate

  // Stage 2: registered product, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: only real pipeline flops are reset; there is no memory array to clear here.
    if (rst) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign P = p_q;

endmodule

// File: tb/tb_top_mul.sv
// tb_top_mul: self-checking bench for top_mul. Three instances (exact 8x8,
// TRUNC=4 8x8, 8-bit output) share one operand stream; each output is compared
// every cycle against a column-sum reference model plus directed constants.
module tb_top_mul;

  logic       clk;
  logic       rst;
  logic [7:0] IN1;
  logic [7:0] IN2;
  logic [15:0] p_exact;
  logic [15:0] p_trunc;
  logic [7:0]  p_narrow;

  int n_tests;
  int n_fail;

  // Previous edge's inputs, used to derive the expected product one edge later.
  logic        prev_rst;
  int unsigned prev_a;
  int unsigned prev_b;

  top_mul #(.width1(8), .width2(8), .outwidth(16), .TRUNC(0)) u_exact (
    .clk(clk), .rst(rst), .IN1(IN1), .IN2(IN2), .P(p_exact)
  );

  top_mul #(.width1(8), .width2(8), .outwidth(16), .TRUNC(4)) u_trunc (
    .clk(clk), .rst(rst), .IN1(IN1), .IN2(IN2), .P(p_trunc)
  );

  top_mul #(.width1(8), .width2(8), .outwidth(8), .TRUNC(0)) u_narrow (
    .clk(clk), .rst(rst), .IN1(IN1), .IN2(IN2), .P(p_narrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Sum of kept partial products (columns >= trunc), reduced mod 2^ow.
  function automatic longint unsigned ref_mul(input int unsigned a, input int unsigned b,
                                              input int trunc, input int ow);
    longint unsigned acc;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if ((i + j >= trunc) && a[i] && b[j]) acc += (64'd1 << (i + j));
      end
    end
    return acc % (64'd1 << ow);
  endfunction

  // Apply one input set, clock one edge, then check all three outputs.
  task automatic cycle(input logic r, input int unsigned a, input int unsigned b);
    logic [31:0] e_exact;
    logic [31:0] e_trunc;
    logic [31:0] e_narrow;
    rst = r;
    IN1 = a[7:0];
    IN2 = b[7:0];
    @(posedge clk);
    #1;
    if (r || prev_rst) begin
      e_exact  = 0;
      e_trunc  = 0;
      e_narrow = 0;
    end else begin
      e_exact  = 32'(ref_mul(prev_a, prev_b, 0, 16));
      e_trunc  = 32'(ref_mul(prev_a, prev_b, 4, 16));
      e_narrow = 32'(ref_mul(prev_a, prev_b, 0, 8));
    end
    check("model_exact", {16'd0, p_exact}, e_exact);
    check("model_trunc", {16'd0, p_trunc}, e_trunc);
    check("model_narrow", {24'd0, p_narrow}, e_narrow);
    prev_rst = r;
    prev_a   = a & 32'hff;
    prev_b   = b & 32'hff;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    prev_rst = 1'b1;
    prev_a   = 0;
    prev_b   = 0;
    rst      = 1'b1;
    IN1      = 8'd0;
    IN2      = 8'd0;

    // Reset held 3 cycles with full-scale operands.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 255, 255);
      check("reset_p", {16'd0, p_exact}, 32'd0);
    end
    cycle(1'b0, 255, 255);
    check("post_rst_1", {16'd0, p_exact}, 32'd0);
    cycle(1'b0, 255, 255);
    check("post_rst_2", {16'd0, p_exact}, 32'd65025);
    check("trunc_255", {16'd0, p_trunc}, 32'd64976);

    // Exact corners; each result shows two edges after it is applied.
    cycle(1'b0, 0, 200);
    cycle(1'b0, 1, 173);
    check("c_0x200", {16'd0, p_exact}, 32'd0);
    cycle(1'b0, 255, 255);
    check("c_1x173", {16'd0, p_exact}, 32'd173);
    cycle(1'b0, 128, 2);
    check("c_255x255", {16'd0, p_exact}, 32'd65025);
    cycle(1'b0, 3, 4);
    check("c_128x2", {16'd0, p_exact}, 32'd256);

    // Streaming 3x4, 10x10, 7x9 back to back.
    cycle(1'b0, 10, 10);
    check("s_12", {16'd0, p_exact}, 32'd12);
    cycle(1'b0, 7, 9);
    check("s_100", {16'd0, p_exact}, 32'd100);
    cycle(1'b0, 15, 1);
    check("s_63", {16'd0, p_exact}, 32'd63);

    // Truncation corners and output-width wrap.
    cycle(1'b0, 16, 1);
    check("t_15x1", {16'd0, p_trunc}, 32'd0);
    cycle(1'b0, 20, 20);
    check("t_16x1", {16'd0, p_trunc}, 32'd16);
    cycle(1'b0, 0, 0);
    check("w_20x20", {24'd0, p_narrow}, 32'd144);
    check("w_20x20_full", {16'd0, p_exact}, 32'd400);

    // Mid-stream reset while 200x3 is in flight: 600 must never appear.
    cycle(1'b0, 200, 3);
    cycle(1'b1, 5, 5);
    check("mr_p0", {16'd0, p_exact}, 32'd0);
    cycle(1'b0, 7, 7);
    check("mr_p1", {16'd0, p_exact}, 32'd0);
    cycle(1'b0, 0, 0);
    check("mr_resume", {16'd0, p_exact}, 32'd49);

    // Randomized stream with occasional resets.
    for (int k = 0; k < 300; k++) begin
      cycle(($urandom_range(0, 31) == 0), $urandom_range(0, 255), $urandom_range(0, 255));
    end
    cycle(1'b0, 0, 0);
    cycle(1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
